// File: rtl/coil_drive_pkg.sv
// rtl/coil_drive_pkg.sv - shared types and defaults for the coil drive sequencer
package coil_drive_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRIVE,
        ST_OFF,
        ST_DRAIN
    } coil_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_MIN_ON  = 12;
    localparam int DEF_MIN_OFF = 12;
    localparam int DEF_MARGIN  = 4;

endpackage

// File: rtl/coil_energy_tracker.sv
// rtl/coil_energy_tracker.sv - saturating coil energy estimate and reversal guard timer
module coil_energy_tracker
    import coil_drive_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int MARGIN = DEF_MARGIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drive_active,
    output logic [CNT_W-1:0] energy,
    output logic             safe_to_reverse
);

    localparam logic [CNT_W-1:0] E_MAX = '1;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD  = CNT_W'(MARGIN);

    logic [CNT_W-1:0] energy_q;
    logic [CNT_W-1:0] zero_cnt_q;

    // Charge while the bridge is driven, discharge through flyback otherwise; clamp at both ends
    always_ff @(posedge clk) begin
        if (rst) begin
            energy_q <= '0;
        end else if (drive_active) begin
            if (energy_q != E_MAX) begin
                energy_q <= energy_q + ONE;
            end
        end else if (energy_q != '0) begin
            energy_q <= energy_q - ONE;
        end
    end

    // Count idle clocks spent at zero energy, held at MARGIN once reached
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_cnt_q <= '0;
        end else if (energy_q != '0) begin
            zero_cnt_q <= '0;
        end else if (zero_cnt_q != HOLD) begin
            zero_cnt_q <= zero_cnt_q + ONE;
        end
    end

    assign energy          = energy_q;
    assign safe_to_reverse = (energy_q == '0) && (zero_cnt_q == HOLD);

endmodule

// File: rtl/coil_drive_sequencer.sv
// rtl/coil_drive_sequencer.sv - pulse-train sequencer producing exclusive H-bridge drive requests
module coil_drive_sequencer
    import coil_drive_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MIN_ON  = DEF_MIN_ON,
    parameter int MIN_OFF = DEF_MIN_OFF,
    parameter int MARGIN  = DEF_MARGIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic             cmd_alt,
    input  logic [CNT_W-1:0] cmd_on_cycles,
    input  logic [7:0]       cmd_pulses,
    input  logic             abort,
    output logic             drive_fwd,
    output logic             drive_rev,
    output logic             busy,
    output logic             done,
    output logic             cmd_err,
    output logic [CNT_W-1:0] energy
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
    // The OFF state lasts MIN_OFF-1 clocks; the DRIVE entry clock adds the last low clock.
    localparam logic [CNT_W-1:0] OFF_THRESH = CNT_W'((MIN_OFF >= 2) ? (MIN_OFF - 2) : 0);

    coil_state_t      state_q, state_d;
    logic             last_dir_q;
    logic             dir_q;
    logic             alt_q;
    logic [CNT_W-1:0] on_cycles_q;
    logic [7:0]       pulses_left_q;
    logic [CNT_W-1:0] on_cnt_q;
    logic [CNT_W-1:0] off_cnt_q;
    logic             drive_fwd_q, drive_rev_q;
    logic             cmd_err_q;

    logic             fwd_d, rev_d;
    logic             accept, reject;
    logic             enter_drive;
    logic             enter_dir;
    logic             pulse_end;
    logic             done_c;
    logic             next_dir;
    logic             safe_to_reverse;
    logic [CNT_W-1:0] on_clamped;

    assign on_clamped = (cmd_on_cycles < MIN_ON_C) ? MIN_ON_C : cmd_on_cycles;
    assign next_dir   = alt_q ? ~last_dir_q : last_dir_q;

    coil_energy_tracker #(
        .CNT_W  (CNT_W),
        .MARGIN (MARGIN)
    ) u_energy (
        .clk             (clk),
        .rst             (rst),
        .drive_active    (drive_fwd_q | drive_rev_q),
        .energy          (energy),
        .safe_to_reverse (safe_to_reverse)
    );

    // Next-state logic and next drive levels; drives are registered so they never glitch
    always_comb begin
        state_d     = state_q;
        fwd_d       = 1'b0;
        rev_d       = 1'b0;
        accept      = 1'b0;
        reject      = 1'b0;
        enter_drive = 1'b0;
        enter_dir   = last_dir_q;
        pulse_end   = 1'b0;
        done_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_pulses == 8'd0) begin
                        reject = 1'b1;
                    end else begin
                        accept = 1'b1;
                        if ((cmd_dir == last_dir_q) || safe_to_reverse) begin
                            state_d     = ST_DRIVE;
                            enter_drive = 1'b1;
                            enter_dir   = cmd_dir;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                end else if (safe_to_reverse) begin
                    state_d     = ST_DRIVE;
                    enter_drive = 1'b1;
                    enter_dir   = dir_q;
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                end else if (on_cnt_q != on_cycles_q) begin
                    fwd_d = (last_dir_q == DIR_FWD);
                    rev_d = (last_dir_q == DIR_REV);
                end else begin
                    state_d   = ST_OFF;
                    pulse_end = 1'b1;
                end
            end
            ST_OFF: begin
                if (abort || (pulses_left_q == 8'd0)) begin
                    state_d = ST_DRAIN;
                end else if ((off_cnt_q >= OFF_THRESH) &&
                             ((next_dir == last_dir_q) || safe_to_reverse)) begin
                    state_d     = ST_DRIVE;
                    enter_drive = 1'b1;
                    enter_dir   = next_dir;
                end
            end
            ST_DRAIN: begin
                if (energy == '0) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, drive outputs and rejection pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drive_fwd_q <= 1'b0;
            drive_rev_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drive_fwd_q <= fwd_d;
            drive_rev_q <= rev_d;
            cmd_err_q   <= reject;
        end
    end

    // Command fields latched at acceptance, direction latched when a pulse starts
    always_ff @(posedge clk) begin
        if (rst) begin
            last_dir_q    <= DIR_FWD;
            dir_q         <= DIR_FWD;
            alt_q         <= 1'b0;
            on_cycles_q   <= '0;
            pulses_left_q <= 8'd0;
        end else begin
            if (accept) begin
                dir_q         <= cmd_dir;
                alt_q         <= cmd_alt;
                on_cycles_q   <= on_clamped;
                pulses_left_q <= cmd_pulses;
            end else if (pulse_end) begin
                pulses_left_q <= pulses_left_q - 8'd1;
            end
            if (enter_drive) begin
                last_dir_q <= enter_dir;
            end
        end
    end

    // On-time and off-time counters
    always_ff @(posedge clk) begin
        if (rst) begin
            on_cnt_q  <= '0;
            off_cnt_q <= '0;
        end else begin
            if (enter_drive) begin
                on_cnt_q <= '0;
            end else if (fwd_d || rev_d) begin
                on_cnt_q <= on_cnt_q + ONE;
            end
            if (pulse_end) begin
                off_cnt_q <= '0;
            end else if ((state_q == ST_OFF) && (off_cnt_q != '1)) begin
                off_cnt_q <= off_cnt_q + ONE;
            end
        end
    end

    assign drive_fwd = drive_fwd_q;
    assign drive_rev = drive_rev_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_c;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_coil_drive_sequencer.sv
// tb/tb_coil_drive_sequencer.sv - directed self-checking bench for coil_drive_sequencer
`timescale 1ns/1ps
module tb_coil_drive_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic        cmd_alt = 1'b0;
    logic [15:0] cmd_on_cycles = 16'd0;
    logic [7:0]  cmd_pulses = 8'd0;
    logic        abort = 1'b0;
    logic        drive_fwd, drive_rev, busy, done, cmd_err;
    logic [15:0] energy;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int overlap = 0;
    int peak = 0;
    logic prev_on = 1'b0;
    logic rise_dir = 1'b0;
    int lens[$];
    int dirs[$];
    int gaps[$];
    int rise_e[$];

    coil_drive_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_dir       (cmd_dir),
        .cmd_alt       (cmd_alt),
        .cmd_on_cycles (cmd_on_cycles),
        .cmd_pulses    (cmd_pulses),
        .abort         (abort),
        .drive_fwd     (drive_fwd),
        .drive_rev     (drive_rev),
        .busy          (busy),
        .done          (done),
        .cmd_err       (cmd_err),
        .energy        (energy)
    );

    always #5 clk = ~clk;

    // Pulse monitor sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (drive_fwd && drive_rev) overlap++;
        if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
        end
        if (cmd_err) err_cnt++;
        if (int'(energy) > peak) peak = int'(energy);
        if ((drive_fwd || drive_rev) && !prev_on) begin
            rise_cyc = cyc;
            rise_dir = drive_rev;
            gaps.push_back(cyc - fall_cyc);
            rise_e.push_back(int'(energy));
        end
        if (!(drive_fwd || drive_rev) && prev_on) begin
            lens.push_back(cyc - rise_cyc);
            dirs.push_back(int'(rise_dir));
            fall_cyc = cyc;
        end
        prev_on = drive_fwd || drive_rev;
    end

    task automatic clear_mon();
        lens.delete(); dirs.delete(); gaps.delete(); rise_e.delete();
        done_cnt = 0; err_cnt = 0; overlap = 0; peak = 0; fall_cyc = cyc;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cmd(input logic d, input logic a, input logic [15:0] on,
                            input logic [7:0] p, input logic ab);
        @(negedge clk);
        clear_mon();
        cmd_valid = 1'b1; cmd_dir = d; cmd_alt = a; cmd_on_cycles = on; cmd_pulses = p; abort = ab;
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_done_timeout got=0 exp=1", name);
        end
        checks++;
        if (energy !== 16'd0) begin
            failures++;
            $display("FAIL %s_energy_at_done got=%0d exp=0", name, energy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if ({drive_fwd, drive_rev} !== 2'b00) begin failures++; $display("FAIL reset_drive got=%b exp=00", {drive_fwd, drive_rev}); end
        checks++; if ({done, cmd_err} !== 2'b00) begin failures++; $display("FAIL reset_done_err got=%b exp=00", {done, cmd_err}); end
        checks++; if (energy !== 16'd0) begin failures++; $display("FAIL reset_energy got=%0d exp=0", energy); end
        rst = 1'b0;
        tick(8);
    endtask

    task automatic test_single();
        send_cmd(1'b0, 1'b0, 16'd20, 8'd1, 1'b0);
        checks++; if (drive_fwd !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL single_accept got=fwd%0b busy%0b rdy%0b exp=fwd0 busy1 rdy0", drive_fwd, busy, cmd_ready); end
        tick(1);
        checks++; if (drive_fwd !== 1'b1) begin failures++; $display("FAIL single_latency got=%0b exp=1", drive_fwd); end
        wait_done(200, "single");
        tick(1);
        checks++; if (lens.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", lens.size()); end
        if (lens.size() >= 1) begin
            checks++; if (lens[0] != 20 || dirs[0] != 0) begin failures++; $display("FAIL single_len got=%0d/dir%0d exp=20/dir0", lens[0], dirs[0]); end
        end
        checks++; if (peak != 20) begin failures++; $display("FAIL single_peak got=%0d exp=20", peak); end
        checks++; if (done_cyc - fall_cyc != 20) begin failures++; $display("FAIL single_done_delay got=%0d exp=20", done_cyc - fall_cyc); end
        checks++; if (done_cnt != 1 || cmd_ready !== 1'b1) begin failures++; $display("FAIL single_done_once got=%0d rdy%0b exp=1 rdy1", done_cnt, cmd_ready); end
    endtask

    task automatic test_clamp();
        // abort offered together with the command in IDLE must not block acceptance
        send_cmd(1'b0, 1'b0, 16'd5, 8'd1, 1'b1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clamp_abort_accept got=%0b exp=1", busy); end
        wait_done(200, "clamp");
        tick(1);
        checks++; if (lens.size() != 1) begin failures++; $display("FAIL clamp_count got=%0d exp=1", lens.size()); end
        if (lens.size() >= 1) begin
            checks++; if (lens[0] != 12) begin failures++; $display("FAIL clamp_len got=%0d exp=12", lens[0]); end
        end
        checks++; if (peak != 12) begin failures++; $display("FAIL clamp_peak got=%0d exp=12", peak); end
    endtask

    task automatic test_same_dir();
        send_cmd(1'b0, 1'b0, 16'd15, 8'd4, 1'b0);
        wait_done(500, "same");
        tick(1);
        checks++; if (lens.size() != 4) begin failures++; $display("FAIL same_count got=%0d exp=4", lens.size()); end
        for (int i = 0; i < lens.size() && i < 4; i++) begin
            checks++; if (lens[i] != 15 || dirs[i] != 0) begin failures++; $display("FAIL same_len%0d got=%0d/dir%0d exp=15/dir0", i, lens[i], dirs[i]); end
        end
        for (int i = 1; i < gaps.size() && i < 4; i++) begin
            checks++; if (gaps[i] != 12) begin failures++; $display("FAIL same_gap%0d got=%0d exp=12", i, gaps[i]); end
        end
    endtask

    task automatic test_alternate();
        send_cmd(1'b0, 1'b1, 16'd30, 8'd3, 1'b0);
        wait_done(600, "alt");
        tick(1);
        checks++; if (lens.size() != 3) begin failures++; $display("FAIL alt_count got=%0d exp=3", lens.size()); end
        for (int i = 0; i < lens.size() && i < 3; i++) begin
            checks++; if (lens[i] != 30 || dirs[i] != (i % 2)) begin failures++; $display("FAIL alt_len%0d got=%0d/dir%0d exp=30/dir%0d", i, lens[i], dirs[i], i % 2); end
        end
        for (int i = 1; i < gaps.size() && i < 3; i++) begin
            checks++; if (gaps[i] < 34 || gaps[i] > 40) begin failures++; $display("FAIL alt_gap%0d got=%0d exp=34..40", i, gaps[i]); end
            checks++; if (rise_e[i] != 0) begin failures++; $display("FAIL alt_energy%0d got=%0d exp=0", i, rise_e[i]); end
        end
        checks++; if (overlap != 0) begin failures++; $display("FAIL alt_overlap got=%0d exp=0", overlap); end
    endtask

    task automatic test_abort();
        int h = 0;
        int guard = 0;
        send_cmd(1'b0, 1'b0, 16'd40, 8'd3, 1'b0);
        while (h < 10 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (drive_fwd) h++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (drive_fwd !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL abort_drop got=fwd%0b busy%0b exp=fwd0 busy1", drive_fwd, busy); end
        wait_done(200, "abort");
        tick(60);
        checks++; if (lens.size() != 1) begin failures++; $display("FAIL abort_pulses got=%0d exp=1", lens.size()); end
        if (lens.size() >= 1) begin
            checks++; if (lens[0] != 10) begin failures++; $display("FAIL abort_len got=%0d exp=10", lens[0]); end
        end
        checks++; if (done_cnt != 1 || cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_done_once got=%0d rdy%0b exp=1 rdy1", done_cnt, cmd_ready); end
    endtask

    task automatic test_reject();
        send_cmd(1'b1, 1'b0, 16'd20, 8'd0, 1'b0);
        checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL reject_err got=%0b exp=1", cmd_err); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL reject_idle got=busy%0b rdy%0b exp=busy0 rdy1", busy, cmd_ready); end
        tick(5);
        checks++; if (err_cnt != 1 || busy !== 1'b0) begin failures++; $display("FAIL reject_once got=%0d busy%0b exp=1 busy0", err_cnt, busy); end
        checks++; if (lens.size() != 0 || drive_rev !== 1'b0) begin failures++; $display("FAIL reject_nodrive got=%0d exp=0", lens.size()); end
    endtask

    task automatic test_reset_mid();
        send_cmd(1'b0, 1'b0, 16'd40, 8'd2, 1'b0);
        tick(6);
        checks++; if (drive_fwd !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%0b exp=1", drive_fwd); end
        rst = 1'b1;
        tick(1);
        checks++; if ({drive_fwd, drive_rev, busy} !== 3'b000) begin failures++; $display("FAIL rstmid_outputs got=%b exp=000", {drive_fwd, drive_rev, busy}); end
        checks++; if (energy !== 16'd0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_energy got=%0d rdy%0b exp=0 rdy1", energy, cmd_ready); end
        rst = 1'b0;
        tick(3);
    endtask

    initial begin
        test_reset();
        test_single();
        test_clamp();
        test_same_dir();
        test_alternate();
        test_abort();
        test_reject();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
